axi_wr_slave: RTL and testbench

AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

---
 rtl/axi_wr_slave.sv | 152 +++++++++++++++
 tb/tb_axi_wr_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slave.sv
// AXI4 write-channel slave backed by a small word memory.
// One outstanding burst; errors are reported with SLVERR and suppress the remaining writes of the burst.
module axi_wr_slave #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 64,
  parameter int AWREADY_DLY = 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ID_W-1:0]              awid,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_W-1:0]              bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [DATA_W-1:0]   dbg_q;
  logic [DATA_W-1:0]   mem [MEM_WORDS];

  logic                aw_hs, w_hs, last_beat, in_range, mem_we;
  logic [ADDR_W-1:0]   word_idx;

  // Reset is folded into awready so a zero delay cannot raise it while areset is held.
  assign awready   = (state_q == S_IDLE) && !areset && (int'(cnt_q) >= AWREADY_DLY);
  assign wready    = (state_q == S_DATA);
  assign bvalid    = (state_q == S_RESP);
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign dbg_data  = dbg_q;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign word_idx  = addr_q >> OFFS;
  assign in_range  = word_idx < ADDR_W'(MEM_WORDS);
  assign last_beat = (beat_q == len_q);
  assign mem_we    = w_hs && !err_q && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = awvalid ? ((cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1) : '0;
        if (aw_hs) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          burst_d = awburst;
          beat_d  = '0;
          err_d   = (awsize != 3'(OFFS)) || awburst[1];
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (burst_q == 2'b01) addr_d = addr_q + ADDR_W'(STRB_W);
          if (!in_range) err_d = 1'b1;
          // Burst closes on whichever of wlast / final beat count arrives first.
          if (wlast || last_beat) begin
            if (wlast != last_beat) err_d = 1'b1;
            bid_d   = id_q;
            bresp_d = err_d ? 2'b10 : 2'b00;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      bid_q   <= '0;
      bresp_q <= '0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      bid_q   <= bid_d;
      bresp_q <= bresp_d;
      dbg_q   <= mem[dbg_addr];
    end
  end

  // Memory is deliberately outside the reset domain so completed writes survive areset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx[IDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: B responses are scoreboarded, memory checked through the debug port.
module tb_axi_wr_slave;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [5:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  axi_wr_slave #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(64), .AWREADY_DLY(1)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  bexp_t       bq[$];
  logic [31:0] mdl [64];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mwrite(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bur, output int lat);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bur; awvalid = 1'b1;
    lat = 0;
    #1;
    while (!awready && lat < 20) begin
      @(posedge aclk); #1; lat++;
    end
    check("aw_timeout", 64'(lat < 20), 1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin
      @(posedge aclk); #1; n++;
    end
    check("w_timeout", 64'(n < 20), 1);
    check("aw_w_ready_excl", 64'(awready && wready), 0);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bur, input int last_at,
                       input logic [31:0] d0, input logic [3:0] strb, input logic [1:0] exp_resp);
    int lat, nb;
    logic err;
    logic [31:0] a, idx;
    bq.push_back({id, exp_resp});
    aw_send(id, addr, len, size, bur, lat);
    check("aw_latency", 64'(lat), 1);
    nb  = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
    err = (size != 3'd2) || bur[1];
    a   = addr;
    for (int i = 0; i < nb; i++) begin
      idx = a >> 2;
      if (!err && idx < 64) mwrite(int'(idx), d0 + 32'(i), strb);
      if (idx >= 64) err = 1'b1;
      if ((i == last_at) != (i == int'(len))) err = 1'b1;
      w_beat(d0 + 32'(i), strb, i == last_at);
      if (bur == 2'b01) a = a + 32'd4;
    end
  endtask

  task automatic b_recv(input int stall);
    int n;
    bexp_t e;
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge aclk); #1; n++;
    end
    check("b_timeout", 64'(n < 20), 1);
    check("b_latency", 64'(n), 0);
    check("bq_nonempty", 64'(bq.size() > 0), 1);
    e = bq.pop_front();
    for (int s = 0; s < stall; s++) begin
      check("b_hold_valid", 64'(bvalid), 1);
      check("b_hold_id", 64'(bid), 64'(e.id));
      check("b_hold_resp", 64'(bresp), 64'(e.resp));
      check("awready_in_resp", 64'(awready), 0);
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    check("bid", 64'(bid), 64'(e.id));
    check("bresp", 64'(bresp), 64'(e.resp));
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bvalid_clear", 64'(bvalid), 0);
  endtask

  task automatic chk_mem(input int idx, input string tag);
    dbg_addr = 6'(idx);
    @(posedge aclk); #1;
    check(tag, 64'(dbg_data), 64'(mdl[idx]));
  endtask

  task automatic chk_word(input int idx, input logic [31:0] val, input string tag);
    dbg_addr = 6'(idx);
    @(posedge aclk); #1;
    check(tag, 64'(dbg_data), 64'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #3;
    check("rst_awready", 64'(awready), 0);
    check("rst_wready", 64'(wready), 0);
    check("rst_bvalid", 64'(bvalid), 0);
    check("rst_bid", 64'(bid), 0);
    check("rst_bresp", 64'(bresp), 0);
    check("rst_dbg", 64'(dbg_data), 0);
    @(posedge aclk); @(posedge aclk); #1;
    areset = 1'b0;

    // INCR 4 beats from word 2
    burst(4'd5, 32'h8, 8'd3, 3'd2, 2'b01, 3, 32'hA0, 4'hF, 2'b00);
    b_recv(0);
    chk_word(2, 32'hA0, "incr_w2");
    chk_word(3, 32'hA1, "incr_w3");
    chk_word(4, 32'hA2, "incr_w4");
    chk_word(5, 32'hA3, "incr_w5");

    // partial strobe merge
    burst(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, 0, 32'h11223344, 4'hF, 2'b00);
    b_recv(0);
    burst(4'd2, 32'h0, 8'd0, 3'd2, 2'b01, 0, 32'hFFFFFFFF, 4'h3, 2'b00);
    b_recv(0);
    chk_word(0, 32'h1122FFFF, "strb_w0");

    // last word, second beat out of range
    burst(4'd3, 32'hFC, 8'd1, 3'd2, 2'b01, 1, 32'h63000000, 4'hF, 2'b10);
    b_recv(0);
    chk_word(63, 32'h63000000, "oor_w63");

    // early wlast
    burst(4'd4, 32'h40, 8'd3, 3'd2, 2'b01, 1, 32'hB0, 4'hF, 2'b10);
    b_recv(0);
    chk_mem(16, "early_w16");
    chk_mem(17, "early_w17");

    // WRAP rejected, memory untouched
    burst(4'd6, 32'h80, 8'd1, 3'd2, 2'b01, 1, 32'h5500, 4'hF, 2'b00);
    b_recv(0);
    burst(4'd6, 32'h80, 8'd1, 3'd2, 2'b10, 1, 32'hC0, 4'hF, 2'b10);
    b_recv(0);
    chk_word(32, 32'h5500, "wrap_w32");
    chk_word(33, 32'h5501, "wrap_w33");

    // bad awsize rejected
    burst(4'd7, 32'h90, 8'd0, 3'd2, 2'b01, 0, 32'h7700, 4'hF, 2'b00);
    b_recv(0);
    burst(4'd7, 32'h90, 8'd0, 3'd1, 2'b01, 0, 32'hE0, 4'hF, 2'b10);
    b_recv(0);
    chk_word(36, 32'h7700, "size_w36");

    // FIXED burst lands on one word
    burst(4'd8, 32'hA0, 8'd2, 3'd2, 2'b00, 2, 32'hD0, 4'hF, 2'b00);
    b_recv(0);
    chk_word(40, 32'hD2, "fixed_w40");

    // missing wlast on final beat
    burst(4'd9, 32'hB0, 8'd1, 3'd2, 2'b01, 5, 32'hF0, 4'hF, 2'b10);
    b_recv(0);
    chk_mem(44, "nolast_w44");
    chk_mem(45, "nolast_w45");

    // response back-pressure with a new address already pending
    burst(4'hC, 32'hE0, 8'd0, 3'd2, 2'b01, 0, 32'h1234, 4'hF, 2'b00);
    awid = 4'hD; awaddr = 32'hE4; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    b_recv(5);
    burst(4'hD, 32'hE4, 8'd0, 3'd2, 2'b01, 0, 32'h5678, 4'hF, 2'b00);
    b_recv(0);
    chk_mem(56, "stall_w56");
    chk_mem(57, "stall_w57");

    // reset during beat 2 abandons the burst
    aw_send(4'hA, 32'hC0, 8'd3, 3'd2, 2'b01, lat);
    w_beat(32'h900, 4'hF, 1'b0);
    mwrite(48, 32'h900, 4'hF);
    w_beat(32'h901, 4'hF, 1'b0);
    mwrite(49, 32'h901, 4'hF);
    wdata = 32'h902; wvalid = 1'b1;
    #2;
    areset = 1'b1;
    #1;
    check("rst_mid_bvalid", 64'(bvalid), 0);
    check("rst_mid_wready", 64'(wready), 0);
    check("rst_mid_awready", 64'(awready), 0);
    check("rst_mid_bid", 64'(bid), 0);
    check("rst_mid_dbg", 64'(dbg_data), 0);
    wvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    burst(4'hB, 32'hD0, 8'd1, 3'd2, 2'b01, 1, 32'h31, 4'hF, 2'b00);
    b_recv(0);
    chk_mem(48, "rst_keep_w48");
    chk_mem(49, "rst_keep_w49");
    chk_mem(52, "post_rst_w52");
    chk_mem(53, "post_rst_w53");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
